// File: rtl/axis_send_scheduler_pkg.sv
// Shared definitions for the AXI-Stream send scheduler.
//   - sched_state_t : scheduler FSM encoding (IDLE=0, LOAD=1, SEND=2, DONE=3)
//   - ADDR_BIT_DEFAULT / NUM_REQ_DEFAULT : default widths used by the top level
package axis_send_scheduler_pkg;

  localparam int ADDR_BIT_DEFAULT = 16;
  localparam int NUM_REQ_DEFAULT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/axis_send_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter used by the send scheduler.
// Picks the first asserted request strictly after the pointer, wrapping.
//   req_vec      in  NUM_REQ  pending requests
//   ptr          in  SEL_BIT  index of the last granted requester
//   grant_onehot out NUM_REQ  one-hot grant (all zero when nothing pending)
//   grant_idx    out SEL_BIT  binary index of the granted requester
module axis_send_scheduler_rr_arbiter
  import axis_send_scheduler_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int SEL_BIT = 2
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [SEL_BIT-1:0] ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [SEL_BIT-1:0] grant_idx
);

  int                 cand;
  logic [SEL_BIT-1:0] cand_idx;
  logic               found;

  // Walk the candidates from farthest to nearest so the nearest pending
  // index after the pointer is the last (winning) assignment.
  always_comb begin
    cand         = 0;
    cand_idx     = '0;
    found        = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = SEL_BIT'(cand);
      if (req_vec[cand_idx]) begin
        grant_idx = cand_idx;
        found     = 1'b1;
      end
    end
    if (found) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/axis_send_scheduler.sv
// Schedules send descriptors from NUM_REQ result banks onto a single
// AXI-Stream send engine, one transfer at a time, in round-robin order.
//   clk, rst            clock / synchronous active-high reset
//   req                 per-requester one-cycle request pulse
//   req_addr_start/end  packed descriptors, slice i for requester i (end exclusive)
//   req_pending         descriptor held and not yet completed
//   req_done            one-cycle pulse when a requester's transfer completes
//   req_err             one-cycle pulse when a request is rejected
//   m_send_enable       one-cycle start strobe to the send engine
//   m_send_done         end-of-transfer pulse from the send engine
//   m_addr_start/end    range handed to the send engine
//   bank_sel            bank whose read data feeds the send engine
//   busy                high whenever the scheduler is not idle
module axis_send_scheduler
  import axis_send_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEFAULT,
  parameter int ADDR_BIT = ADDR_BIT_DEFAULT,
  parameter int SEL_BIT  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr_start,
  input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr_end,
  output logic [NUM_REQ-1:0]           req_pending,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [NUM_REQ-1:0]           req_err,
  output logic                         m_send_enable,
  input  logic                         m_send_done,
  output logic [ADDR_BIT-1:0]          m_addr_start,
  output logic [ADDR_BIT-1:0]          m_addr_end,
  output logic [SEL_BIT-1:0]           bank_sel,
  output logic                         busy
);

  sched_state_t       state;
  sched_state_t       state_nxt;
  logic               load_grant;

  logic [ADDR_BIT-1:0] desc_start [NUM_REQ];
  logic [ADDR_BIT-1:0] desc_end   [NUM_REQ];

  logic [NUM_REQ-1:0] range_ok;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] reject;

  logic [SEL_BIT-1:0] rr_ptr;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [SEL_BIT-1:0] grant_idx;
  logic               any_grant;

  // Request capture: a slot accepts only when free and the range is non-empty.
  // Anything else is a rejection; the DONE cycle still counts as occupied.
  always_comb begin
    range_ok = '0;
    accept   = '0;
    reject   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      range_ok[i] = req_addr_end[i*ADDR_BIT +: ADDR_BIT] >
                    req_addr_start[i*ADDR_BIT +: ADDR_BIT];
      accept[i]   = req[i] & ~req_pending[i] & range_ok[i];
      reject[i]   = req[i] & ~accept[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        desc_start[i] <= req_addr_start[i*ADDR_BIT +: ADDR_BIT];
        desc_end[i]   <= req_addr_end[i*ADDR_BIT +: ADDR_BIT];
      end
    end
  end

  axis_send_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SEL_BIT (SEL_BIT)
  ) u_rr_arbiter (
    .req_vec      (req_pending),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  assign any_grant = |grant_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    load_grant    = 1'b0;
    m_send_enable = 1'b0;
    busy          = 1'b1;
    req_done      = '0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (any_grant) begin
          load_grant = 1'b1;
          state_nxt  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        m_send_enable = 1'b1;
        state_nxt     = ST_SEND;
      end
      ST_SEND: begin
        if (m_send_done) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        req_done[bank_sel] = 1'b1;
        state_nxt          = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // bank_sel doubles as the index of the transfer in flight; it and the
  // address range are only written on the IDLE->LOAD edge, so they hold
  // steady through SEND and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pending  <= '0;
      req_err      <= '0;
      m_addr_start <= '0;
      m_addr_end   <= '0;
      bank_sel     <= '0;
      rr_ptr       <= SEL_BIT'(NUM_REQ - 1);
    end else begin
      req_pending <= (req_pending | accept) & ~req_done;
      req_err     <= reject;
      if (load_grant) begin
        m_addr_start <= desc_start[grant_idx];
        m_addr_end   <= desc_end[grant_idx];
        bank_sel     <= grant_idx;
      end
      if (state == ST_DONE) begin
        rr_ptr <= bank_sel;
      end
    end
  end

endmodule

// File: tb/tb_axis_send_scheduler.sv
// Self-checking bench for axis_send_scheduler: directed scenarios plus
// randomized traffic, with a timestamped transaction model feeding
// expectation queues that a separate monitor drains.
module tb_axis_send_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int ADDR_BIT = 16;
  localparam int SEL_BIT  = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*ADDR_BIT-1:0] req_addr_start;
  logic [NUM_REQ*ADDR_BIT-1:0] req_addr_end;
  logic [NUM_REQ-1:0]          req_pending;
  logic [NUM_REQ-1:0]          req_done;
  logic [NUM_REQ-1:0]          req_err;
  logic                        m_send_enable;
  logic                        m_send_done;
  logic [ADDR_BIT-1:0]         m_addr_start;
  logic [ADDR_BIT-1:0]         m_addr_end;
  logic [SEL_BIT-1:0]          bank_sel;
  logic                        busy;

  axis_send_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .ADDR_BIT (ADDR_BIT),
    .SEL_BIT  (SEL_BIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_addr_start (req_addr_start),
    .req_addr_end   (req_addr_end),
    .req_pending    (req_pending),
    .req_done       (req_done),
    .req_err        (req_err),
    .m_send_enable  (m_send_enable),
    .m_send_done    (m_send_done),
    .m_addr_start   (m_addr_start),
    .m_addr_end     (m_addr_end),
    .bank_sel       (bank_sel),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int g; int s; int e; } xfer_t;
  typedef struct { int cyc; int mask; } pulse_t;

  xfer_t  exp_start[$];
  pulse_t exp_done[$];
  pulse_t exp_err[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  bit eng_hold = 1'b0;

  int drv_s [NUM_REQ];
  int drv_e [NUM_REQ];

  int   log_g[$];
  int   log_s[$];
  int   log_e[$];
  int   en_cyc;
  int   req_cyc;
  int   done_cnt;
  logic [NUM_REQ-1:0] err_seen;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // ---------------- reference model (timestamped transactions) ----------
  bit [NUM_REQ-1:0] m_pend, pend_before;
  int m_s [NUM_REQ];
  int m_e [NUM_REQ];
  int m_last, m_g, m_gedge, m_dedge, m_free_at;
  bit m_active, m_dseen;
  int ms, me, mg, merr;

  initial begin
    m_pend = '0; m_active = 0; m_dseen = 0; m_last = NUM_REQ - 1;
    m_g = 0; m_gedge = 0; m_dedge = 0; m_free_at = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_pend = '0; m_active = 0; m_dseen = 0; m_last = NUM_REQ - 1;
        m_free_at = cyc + 1;
        exp_start.delete(); exp_done.delete(); exp_err.delete();
      end else begin
        pend_before = m_pend;
        merr = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req[i]) begin
            ms = int'(req_addr_start[i*ADDR_BIT +: ADDR_BIT]);
            me = int'(req_addr_end[i*ADDR_BIT +: ADDR_BIT]);
            if (pend_before[i] || me <= ms) merr |= (1 << i);
            else begin m_pend[i] = 1'b1; m_s[i] = ms; m_e[i] = me; end
          end
        end
        if (merr != 0) exp_err.push_back('{cyc, merr});
        if (!m_active && cyc >= m_free_at && pend_before != 0) begin
          mg = -1;
          for (int k = 1; k <= NUM_REQ; k++)
            if (mg < 0 && pend_before[(m_last + k) % NUM_REQ]) mg = (m_last + k) % NUM_REQ;
          exp_start.push_back('{cyc, mg, m_s[mg], m_e[mg]});
          m_active = 1; m_dseen = 0; m_g = mg; m_gedge = cyc;
        end else if (m_active && !m_dseen && cyc >= m_gedge + 2 && m_send_done) begin
          exp_done.push_back('{cyc, 1 << m_g});
          m_dseen = 1; m_dedge = cyc;
        end else if (m_active && m_dseen && cyc == m_dedge + 1) begin
          m_pend[m_g] = 1'b0; m_last = m_g; m_active = 0; m_free_at = cyc + 1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  xfer_t  cur;
  xfer_t  xs;
  pulse_t xp;
  int     exp_mask;

  initial begin
    cur = '{0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("req_pending", int'(req_pending), int'(m_pend));
        chk("busy", int'(busy), int'(m_active));

        while (exp_start.size() > 0 && exp_start[0].cyc < cyc) begin
          void'(exp_start.pop_front());
          flag_fail("send_enable_missing");
        end
        if (m_send_enable) begin
          if (exp_start.size() == 0 || exp_start[0].cyc != cyc) begin
            flag_fail("send_enable_unexpected");
          end else begin
            xs = exp_start.pop_front();
            chk("bank_sel", int'(bank_sel), xs.g);
            chk("m_addr_start", int'(m_addr_start), xs.s);
            chk("m_addr_end", int'(m_addr_end), xs.e);
            cur = xs;
            log_g.push_back(int'(bank_sel));
            log_s.push_back(int'(m_addr_start));
            log_e.push_back(int'(m_addr_end));
            en_cyc = cyc;
          end
        end else if (busy) begin
          chk("hold_bank_sel", int'(bank_sel), cur.g);
          chk("hold_addr_start", int'(m_addr_start), cur.s);
          chk("hold_addr_end", int'(m_addr_end), cur.e);
        end

        while (exp_done.size() > 0 && exp_done[0].cyc < cyc) begin
          void'(exp_done.pop_front());
          flag_fail("req_done_missing");
        end
        exp_mask = 0;
        if (exp_done.size() > 0 && exp_done[0].cyc == cyc) begin
          xp = exp_done.pop_front();
          exp_mask = xp.mask;
        end
        chk("req_done", int'(req_done), exp_mask);
        for (int i = 0; i < NUM_REQ; i++) if (req_done[i]) done_cnt++;

        while (exp_err.size() > 0 && exp_err[0].cyc < cyc) begin
          void'(exp_err.pop_front());
          flag_fail("req_err_missing");
        end
        exp_mask = 0;
        if (exp_err.size() > 0 && exp_err[0].cyc == cyc) begin
          xp = exp_err.pop_front();
          exp_mask = xp.mask;
        end
        chk("req_err", int'(req_err), exp_mask);
        err_seen = err_seen | req_err;
      end
    end
  end

  // ---------------- send engine model ----------------
  int eng_cnt;
  initial begin
    eng_cnt = 0;
    m_send_done = 1'b0;
    forever begin
      @(negedge clk);
      m_send_done = 1'b0;
      if (rst) eng_cnt = 0;
      else if (eng_hold) eng_cnt = eng_cnt;
      else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) m_send_done = 1'b1;
      end else if (m_send_enable) eng_cnt = 1 + int'($urandom_range(0, 4));
      else if (!busy && $urandom_range(0, 9) == 0) m_send_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pack_addrs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr_start[i*ADDR_BIT +: ADDR_BIT] = ADDR_BIT'(drv_s[i]);
      req_addr_end[i*ADDR_BIT +: ADDR_BIT]   = ADDR_BIT'(drv_e[i]);
    end
  endtask

  task automatic issue(input logic [NUM_REQ-1:0] mask);
    @(negedge clk);
    req = mask;
    pack_addrs();
    @(negedge clk);
    req = '0;
    req_cyc = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 300 && !(busy == 1'b0 && req_pending == '0 && exp_start.size() == 0 &&
                        exp_done.size() == 0 && exp_err.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) flag_fail("idle_timeout");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    log_g.delete(); log_s.delete(); log_e.delete();
    err_seen = '0;
    done_cnt = 0;
  endtask

  int rs, re;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    req_addr_start = '0;
    req_addr_end = '0;
    err_seen = '0;
    done_cnt = 0;
    en_cyc = 0;
    req_cyc = 0;
    for (int i = 0; i < NUM_REQ; i++) begin drv_s[i] = 0; drv_e[i] = 0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(req_pending), 0);
    chk("rst_enable", int'(m_send_enable), 0);
    chk("rst_addr_start", int'(m_addr_start), 0);
    chk("rst_addr_end", int'(m_addr_end), 0);
    chk("rst_bank_sel", int'(bank_sel), 0);
    chk("rst_done", int'(req_done), 0);
    chk("rst_err", int'(req_err), 0);

    // single request from bank 0
    clear_logs();
    drv_s[0] = 16'h0100; drv_e[0] = 16'h0110;
    issue(4'b0001);
    wait_idle();
    chk("single_count", log_g.size(), 1);
    if (log_g.size() == 1) begin
      chk("single_bank", log_g[0], 0);
      chk("single_start", log_s[0], 16'h0100);
      chk("single_end", log_e[0], 16'h0110);
    end
    chk("single_latency", en_cyc - req_cyc, 1);
    chk("single_done_cnt", done_cnt, 1);

    // all four at once, from reset pointer
    do_reset();
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++) begin
      drv_s[i] = 16'h1000 + i * 16'h40;
      drv_e[i] = drv_s[i] + 16'h10 + i;
    end
    issue(4'b1111);
    wait_idle();
    chk("all4_count", log_g.size(), 4);
    for (int i = 0; i < NUM_REQ; i++) if (i < log_g.size()) chk("all4_order", log_g[i], i);
    chk("all4_done_cnt", done_cnt, 4);

    // 1 first, then 0 and 2 arrive while 1 is in flight: 2 must precede 0
    do_reset();
    clear_logs();
    issue(4'b0010);
    issue(4'b0101);
    wait_idle();
    chk("rr_count", log_g.size(), 3);
    if (log_g.size() == 3) begin
      chk("rr_first", log_g[0], 1);
      chk("rr_second", log_g[1], 2);
      chk("rr_third", log_g[2], 0);
    end

    // empty range is rejected
    clear_logs();
    drv_s[2] = 16'h0020; drv_e[2] = 16'h0020;
    issue(4'b0100);
    repeat (4) @(negedge clk);
    chk("empty_err", int'(err_seen), 4'b0100);
    chk("empty_no_send", log_g.size(), 0);
    chk("empty_pending", int'(req_pending), 0);

    // resubmission while pending is rejected; original descriptor is used
    do_reset();
    clear_logs();
    drv_s[1] = 16'h0300; drv_e[1] = 16'h0340;
    issue(4'b0010);
    drv_s[1] = 16'h0500; drv_e[1] = 16'h0580;
    issue(4'b0010);
    wait_idle();
    chk("dup_err", int'(err_seen), 4'b0010);
    chk("dup_count", log_g.size(), 1);
    if (log_g.size() == 1) begin
      chk("dup_start", log_s[0], 16'h0300);
      chk("dup_end", log_e[0], 16'h0340);
    end

    // reset during SEND with three descriptors held
    clear_logs();
    eng_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin drv_s[i] = 16'h2000 + i; drv_e[i] = 16'h2100; end
    issue(4'b0111);
    for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", int'(busy), 1);
    chk("midrst_pending_before", int'(req_pending), 4'b0111);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pending", int'(req_pending), 0);
    chk("midrst_done", int'(req_done), 0);
    repeat (3) @(negedge clk);
    eng_hold = 1'b0;
    chk("midrst_no_done", done_cnt, 0);
    wait_idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        rs = int'($urandom_range(0, 16'hfff0));
        if ($urandom_range(0, 4) == 0) re = int'($urandom_range(0, rs));
        else re = rs + int'($urandom_range(1, 15));
        drv_s[i] = rs;
        drv_e[i] = re;
      end
      req = ($urandom_range(0, 2) == 0) ? NUM_REQ'($urandom_range(0, 15)) : '0;
      pack_addrs();
    end
    @(negedge clk);
    req = '0;
    wait_idle();

    chk("leftover_start", exp_start.size(), 0);
    chk("leftover_done", exp_done.size(), 0);
    chk("leftover_err", exp_err.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_send_scheduler.md
AXIS_SEND_SCHEDULER -- requirements
Module: axis_send_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (result banks) sharing the AXI-Stream send engine, range 2..8.
REQ-002 Parameter ADDR_BIT, default 16, word-address width of descriptors and send-engine address ports.
REQ-003 Parameter SEL_BIT, default 2, width of bank_sel; SHALL equal clog2(NUM_REQ).
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  NUM_REQ  per-requester one-cycle send request pulse.
REQ-007 req_addr_start  in  NUM_REQ*ADDR_BIT  descriptor start address; slice i belongs to requester i.
REQ-008 req_addr_end  in  NUM_REQ*ADDR_BIT  descriptor end address, exclusive.
REQ-009 req_pending  out  NUM_REQ  descriptor i held and not yet completed.
REQ-010 req_done  out  NUM_REQ  one-cycle pulse when requester i's transfer completes.
REQ-011 req_err  out  NUM_REQ  one-cycle pulse when requester i's request is rejected.
REQ-012 m_send_enable  out  1  start strobe to send engine.
REQ-013 m_send_done  in  1  end-of-transfer pulse from send engine (coincides with tlast beat).
REQ-014 m_addr_start, m_addr_end  out  ADDR_BIT each  range driven to send engine.
REQ-015 bank_sel  out  SEL_BIT  selects which bank's read_data feeds the send engine.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 Request capture: req[i] high with req_pending[i]=0 and end>start SHALL latch both addresses and set req_pending[i] on the next edge.
REQ-018 req[i] high while req_pending[i]=1 SHALL be ignored; descriptor unchanged, req_err[i] pulses one cycle later.
REQ-019 req[i] with end<=start (unsigned) SHALL not latch; req_err[i] pulses one cycle later.
REQ-020 FSM states: IDLE, LOAD, SEND, DONE.
REQ-021 IDLE: if any pending bit set, select grant g by round-robin (first pending index after last grant, wrapping), register m_addr_start/m_addr_end/bank_sel from descriptor g, go LOAD; else stay.
REQ-022 Round-robin pointer resets to NUM_REQ-1 so requester 0 wins first.
REQ-023 LOAD: m_send_enable=1 for exactly this one cycle; go SEND.
REQ-024 SEND: hold m_addr_*, bank_sel stable; on m_send_done go DONE; no timeout.
REQ-025 DONE: clear req_pending[g], pulse req_done[g], set pointer to g; go IDLE.
REQ-026 m_send_done outside SEND SHALL be ignored.
REQ-027 req[g] in the DONE cycle is treated as pending (REQ-018: rejected); requester resubmits after req_done.
REQ-028 Latency: req at cycle N with scheduler idle -> pending at N+1, LOAD at N+2, m_send_enable high during N+2 only.
REQ-029 Simultaneous requests all latch in one cycle; they are served in round-robin order, one transfer at a time.
REQ-030 m_addr_end-m_addr_start SHALL equal transfer length; no arithmetic on addresses inside this block.

Reset
REQ-031 rst: state IDLE, req_pending=0, req_done=0, req_err=0, m_send_enable=0, m_addr_*=0, bank_sel=0, busy=0, pointer=NUM_REQ-1.
REQ-032 rst mid-transfer SHALL drop all pending descriptors without req_done; send engine is reset by the same rst.

Structure
REQ-033 Shared package: state encoding constants (IDLE=0, LOAD=1, SEND=2, DONE=3) and default ADDR_BIT.
REQ-034 One sub-module: rr_arbiter (NUM_REQ request vector + pointer in, one-hot grant and index out, combinational).

Verification
REQ-035 Single: req[0] start=0x0100 end=0x0110 -> m_send_enable one cycle, m_addr 0x0100/0x0110, bank_sel=0; req_done[0] cycle after m_send_done.
REQ-036 All four req same cycle -> grants in order 0,1,2,3; four req_done pulses, none overlapping.
REQ-037 After grant 1 completes, req 0 and 2 pending -> 2 served before 0.
REQ-038 req[2] start=0x20 end=0x20 -> req_err[2] pulse, req_pending[2] stays 0, no m_send_enable.
REQ-039 req[1] repeated while pending with different addresses -> req_err[1], transfer uses original descriptor.
REQ-040 rst asserted in SEND with 3 pending -> next cycle busy=0, req_pending=0, no req_done.
